// File: rtl/pipelined_adder_nbit_pkg.sv
// Shared types, default sizing and the chunk adder used by every pipeline stage.
package adder_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int ADDER_CHUNK = 8;
    // Widest chunk chunk_add can handle; CHUNK above this is rejected at elaboration.
    localparam int CHUNK_MAX   = 64;

    typedef struct packed {
        logic                   valid;
        logic                   carry;
        logic [ADDER_WIDTH-1:0] sum;
        logic [ADDER_WIDTH-1:0] a;
        logic [ADDER_WIDTH-1:0] b;
    } stage_t;

    // Operands arrive zero-extended; the caller picks {cout,sum} at its own chunk width.
    function automatic logic [CHUNK_MAX:0] chunk_add(input logic [CHUNK_MAX-1:0] a,
                                                     input logic [CHUNK_MAX-1:0] b,
                                                     input logic                 cin);
        return {1'b0, a} + {1'b0, b} + {{CHUNK_MAX{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// Operand/result valid-ready bus of the chunk-pipelined adder.
// in_sub exists only when ADDER_SUB_EN is defined.
interface pipelined_adder_nbit_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef ADDER_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
`ifdef ADDER_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
`ifdef ADDER_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/pipelined_adder_nbit_stage.sv
// One registered chunk stage: adds chunk IDX with the incoming carry and
// forwards the partial sum and operands; holds everything while stalled.
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CHUNK = ADDER_CHUNK,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    input  logic             prev_carry,
    input  logic [WIDTH-1:0] prev_sum,
    input  logic [WIDTH-1:0] prev_a,
    input  logic [WIDTH-1:0] prev_b,
    input  logic             next_adv,
    output logic             adv,
    output logic             valid,
    output logic             carry,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);
    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]   res;
    logic [WIDTH-1:0] sum_d;

    // An empty stage always accepts, so bubbles collapse.
    assign adv = !valid || next_adv;

    always_comb begin
        res   = (CHUNK+1)'(chunk_add(CHUNK_MAX'(prev_a[LO +: CHUNK]),
                                     CHUNK_MAX'(prev_b[LO +: CHUNK]), prev_carry));
        sum_d = prev_sum;
        sum_d[LO +: CHUNK] = res[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            carry <= 1'b0;
            sum   <= '0;
            a     <= '0;
            b     <= '0;
        end else if (adv) begin
            valid <= prev_valid;
            if (prev_valid) begin
                carry <= res[CHUNK];
                sum   <= sum_d;
                a     <= prev_a;
                b     <= prev_b;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// WIDTH-bit adder split into WIDTH/CHUNK registered chunk stages, one result per clock.
// Define ADDER_SUB_EN to add the in_sub (a - b) mode.
module pipelined_adder_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CHUNK = ADDER_CHUNK
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_adder_nbit_if.slave bus
);
    localparam int NUM_STAGES = WIDTH / CHUNK;

    if ((WIDTH % CHUNK) != 0 || CHUNK > CHUNK_MAX || CHUNK < 1) begin : g_bad_cfg
        $error("pipelined_adder_nbit: WIDTH=%0d must be a multiple of CHUNK=%0d (CHUNK <= %0d)",
               WIDTH, CHUNK, CHUNK_MAX);
    end

    // Element k feeds stage k; element k+1 is stage k's register.
    logic [NUM_STAGES:0]            vld_pipe;
    logic [NUM_STAGES:0]            cry;
    logic [NUM_STAGES:0][WIDTH-1:0] sum;
    logic [NUM_STAGES:0][WIDTH-1:0] opa;
    logic [NUM_STAGES:0][WIDTH-1:0] opb;
    logic                           unused_ops;

`ifdef ADDER_SUB_EN
    // Two's-complement subtract: invert b and force the carry-in.
    assign opb[0] = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cry[0] = bus.in_sub ? 1'b1 : bus.in_cin;
`else
    assign opb[0] = bus.in_b;
    assign cry[0] = bus.in_cin;
`endif
    assign vld_pipe[0] = bus.in_valid;
    assign opa[0]      = bus.in_a;
    assign sum[0]      = '0;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic adv_k;
        logic nxt_adv;

        if (k == NUM_STAGES - 1) begin : g_last
            assign nxt_adv = bus.out_ready;
        end else begin : g_mid
            assign nxt_adv = g_stage[k+1].adv_k;
        end

        adder_stage #(
            .WIDTH(WIDTH),
            .CHUNK(CHUNK),
            .IDX  (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .prev_valid(vld_pipe[k]),
            .prev_carry(cry[k]),
            .prev_sum  (sum[k]),
            .prev_a    (opa[k]),
            .prev_b    (opb[k]),
            .next_adv  (nxt_adv),
            .adv       (adv_k),
            .valid     (vld_pipe[k+1]),
            .carry     (cry[k+1]),
            .sum       (sum[k+1]),
            .a         (opa[k+1]),
            .b         (opb[k+1])
        );
    end

    assign bus.in_ready  = g_stage[0].adv_k & rst_n;
    assign bus.out_valid = vld_pipe[NUM_STAGES];
    assign bus.out_sum   = sum[NUM_STAGES];
    assign bus.out_cout  = cry[NUM_STAGES];

    // Operands leaving the last stage have no consumer.
    assign unused_ops = ^{opa[NUM_STAGES], opb[NUM_STAGES]};

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Scoreboard bench: the driver queues the expected result of each accepted beat,
// the monitor pops and compares on every out_valid & out_ready.
module tb_pipelined_adder_nbit;
    import adder_pkg::*;

    localparam int W  = 32;
    localparam int C  = 8;
    localparam int NS = W / C;

    typedef struct packed {
        logic         cout;
        logic [W-1:0] sum;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_nbit_if #(.WIDTH(W))  bus ();
    pipelined_adder_nbit_if #(.WIDTH(64)) bus64 ();
    pipelined_adder_nbit_if #(.WIDTH(32)) bus1 ();

    pipelined_adder_nbit #(.WIDTH(W),  .CHUNK(C))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    pipelined_adder_nbit #(.WIDTH(64), .CHUNK(16)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));
    pipelined_adder_nbit #(.WIDTH(32), .CHUNK(32)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    res_t exp_q[$];
    res_t mon_e;
    int   errors    = 0;
    int   checks    = 0;
    int   outs      = 0;
    int   cyc       = 0;
    int   ordy_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        case (ordy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got sum %0h with no beat outstanding", bus.out_sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_sum", 64'(bus.out_sum), 64'(mon_e.sum));
                check("out_cout", 64'(bus.out_cout), 64'(mon_e.cout));
                outs++;
            end
        end
    end

    // Presents one beat and waits (bounded) for it to be accepted.
    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input res_t e);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (rst_n && bus.in_ready) begin
                acc = 1'b1;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          c0;
        int          o0;
        int          acc;
        logic [W-1:0] held;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic        rc;

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_a = '0; bus64.in_b = '0; bus64.in_cin = 1'b0; bus64.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.out_ready = 1'b1;
`ifdef ADDER_SUB_EN
        bus.in_sub = 1'b0; bus64.in_sub = 1'b0; bus1.in_sub = 1'b0;
`endif

        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_sum",   64'(bus.out_sum),   64'(0));
        check("rst_out_cout",  64'(bus.out_cout),  64'(0));
        check("rst_in_ready",  64'(bus.in_ready),  64'(0));

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;

        // FFFFFFFF + 1 wraps to 0 with carry out; also measures latency.
        beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{1'b1, 32'h0000_0000});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        check("latency", 64'(n), 64'(NS));
        @(posedge clk); #1;

        beat(32'h1234_5678, 32'h8765_4321, 1'b1, '{1'b0, 32'h9999_999A});
        drain("dir_drain");

        // Back-to-back stream: one accept per clock.
        o0 = outs;
        c0 = cyc;
        for (int i = 0; i < 200; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
            beat(ra, rb, rc, model(ra, rb, rc));
        end
        check("stream_rate", 64'(cyc - c0), 64'(200));
        drain("stream_drain");
        check("stream_count", 64'(outs - o0), 64'(200));

        // Backpressure: exactly NS beats fit, output held stable.
        ordy_mode = 2;
        o0 = outs;
        acc = 0;
        held = '0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'h1111_1111 * 32'(acc + 1);
            bus.in_b     = 32'hF0F0_F0F0 ^ 32'(acc);
            bus.in_cin   = 1'b0;
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(bus.in_a, bus.in_b, 1'b0));
                acc++;
            end
            if (i == 5) held = bus.out_sum;
            if (i == 9) begin
                check("bp_in_ready",  64'(bus.in_ready),  64'(0));
                check("bp_out_valid", 64'(bus.out_valid), 64'(1));
                check("bp_sum_stable", 64'(bus.out_sum),  64'(held));
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("bp_accepts", 64'(acc), 64'(NS));
        ordy_mode = 0;
        drain("bp_drain");
        check("bp_count", 64'(outs - o0), 64'(NS));

        // Random in_valid gaps and out_ready toggling.
        ordy_mode = 1;
        o0 = outs;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(1) == 1) begin
                @(posedge clk); #1;
            end
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
            beat(ra, rb, rc, model(ra, rb, rc));
        end
        ordy_mode = 0;
        drain("rand_drain");
        check("rand_count", 64'(outs - o0), 64'(1000));

        // Asynchronous reset with beats in flight.
        ordy_mode = 2;
        beat(32'h0000_0001, 32'h0000_0002, 1'b0, '{1'b0, 32'h0000_0003});
        beat(32'h0000_0010, 32'h0000_0020, 1'b0, '{1'b0, 32'h0000_0030});
        beat(32'h0000_0100, 32'h0000_0200, 1'b0, '{1'b0, 32'h0000_0300});
        @(posedge clk); #1;
        check("pre_rst_valid", 64'(bus.out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.out_valid), 64'(0));
        check("async_rst_sum",   64'(bus.out_sum),   64'(0));
        check("async_rst_ready", 64'(bus.in_ready),  64'(0));
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ordy_mode = 0;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.in_ready), 64'(1));
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        check("no_stale_beat", 64'(n), 64'(0));
        @(posedge clk); #1;
        beat(32'h0000_FFFF, 32'h0000_0001, 1'b0, '{1'b0, 32'h0001_0000});
        drain("post_rst_drain");

`ifdef ADDER_SUB_EN
        bus.in_sub = 1'b1;
        beat(32'h0000_0005, 32'h0000_0007, 1'b0, '{1'b0, 32'hFFFF_FFFE});
        beat(32'h0000_0007, 32'h0000_0005, 1'b0, '{1'b1, 32'h0000_0002});
        bus.in_sub = 1'b0;
        drain("sub_drain");
`endif

        // 64-bit, 16-bit chunks: four stages.
        bus64.in_valid = 1'b1;
        bus64.in_a     = 64'h0000_FFFF_FFFF_FFFF;
        bus64.in_b     = 64'h0000_0000_0000_0001;
        bus64.in_cin   = 1'b0;
        @(negedge clk);
        check("w64_in_ready", 64'(bus64.in_ready), 64'(1));
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus64.out_valid && n < 20);
        check("w64_latency", 64'(n), 64'(4));
        check("w64_sum",  bus64.out_sum, 64'h0001_0000_0000_0000);
        check("w64_cout", 64'(bus64.out_cout), 64'(0));
        @(posedge clk); #1;

        // CHUNK == WIDTH: single stage.
        bus1.in_valid = 1'b1;
        bus1.in_a     = 32'hFFFF_FFFF;
        bus1.in_b     = 32'hFFFF_FFFF;
        bus1.in_cin   = 1'b1;
        @(negedge clk);
        check("w1_in_ready", 64'(bus1.in_ready), 64'(1));
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.out_valid && n < 20);
        check("w1_latency", 64'(n), 64'(1));
        check("w1_sum",  64'(bus1.out_sum),  64'h0000_0000_FFFF_FFFF);
        check("w1_cout", 64'(bus1.out_cout), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
